system_qsys_nios2_oci_dct_capture: RTL

Parametrised data-capture-trace (DCT) monitor for the Nios II OCI debug path, the working successor to the stub OCI test bench. Samples the OCI `dct_buffer`/`dct_count` pair whenever the count changes and stores each sample in an on-chip FIFO. Freezes capture on `test_ending` and drains the captured entries through a valid/request read port once `test_has_ended` is asserted. Reports overflow and a saturating drop count for post-test inspection.

---
 rtl/system_qsys_nios2_oci_dct_capture.sv | 137 +++++++++++++
 1 files changed

// File: rtl/system_qsys_nios2_oci_dct_capture.sv
// system_qsys_nios2_oci_dct_capture
// Data-capture-trace monitor for the Nios II OCI debug path. Samples the
// {dct_count, dct_buffer} pair whenever the count changes while capturing,
// stores samples in an on-chip FIFO, freezes on test_ending and drains
// through a valid/request read port once test_has_ended is asserted.
// Optional build macro: OCI_DCT_CAPTURE_WRAP_EN -- when defined a capture
// into a full FIFO overwrites the oldest entry; otherwise it is discarded.
module system_qsys_nios2_oci_dct_capture #(
  parameter int unsigned DCT_W = 30,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DCT_W-1:0]           dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  input  logic                       rd_req,
  output logic [CNT_W+DCT_W-1:0]     rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  output logic [1:0]                 state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned DW = CNT_W + DCT_W;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    FROZEN  = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_prev_count;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_overflow;
  logic [7:0]        r_drop_count;
  logic [DW-1:0]     r_rd_data;
  logic              r_rd_valid;
  logic [DW-1:0]     r_mem [DEPTH];

  logic              w_strobe;
  logic              w_pop;
  logic              w_full;
  logic              w_wr_ok;
  logic              w_ovf;
  logic              w_mem_we;
  logic              w_rd_adv;

  assign w_strobe = (dct_count != r_prev_count) && (r_state == CAPTURE);
  assign w_pop    = rd_req && (r_level != '0);
  assign w_full   = (r_level == LW'(DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign w_wr_ok  = w_strobe && (!w_full || w_pop);
  assign w_ovf    = w_strobe && w_full && !w_pop;

`ifdef OCI_DCT_CAPTURE_WRAP_EN
  assign w_mem_we = w_wr_ok || w_ovf;
  assign w_rd_adv = w_pop || w_ovf;
`else
  assign w_mem_we = w_wr_ok;
  assign w_rd_adv = w_pop;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= CAPTURE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CAPTURE: if (test_ending)                     w_state_nxt = FROZEN;
      FROZEN:  if (test_has_ended)                  w_state_nxt = DRAIN;
      DRAIN:   if ((r_level == '0) && !w_pop)       w_state_nxt = DONE;
      DONE:                                         w_state_nxt = DONE;
      default:                                      w_state_nxt = CAPTURE;
    endcase
  end

  // Previous-count tracker, pointers, level and overflow bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_prev_count <= dct_count;
      if (w_mem_we) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr_ok && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_wr_ok && w_pop) r_level <= r_level - LW'(1);
      if (w_ovf) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  // Read port: registered data with one-cycle valid pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  // Sample storage; contents need no reset
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr] <= {dct_count, dct_buffer};
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign state      = r_state;

endmodule
